// File: rtl/maxpool_2x2_64channel_layer5_pkg.sv
// Shared constants and lane helpers for the layer-5 2x2 max-pool stage.
package maxpool_2x2_64channel_layer5_pkg;

  localparam int unsigned DATA_WIDHT_DEF = 32;
  localparam int unsigned IMG_WIDHT_DEF  = 44;
  localparam int unsigned IMG_HEIGHT_DEF = 44;
  localparam int unsigned CHANNELS       = 64;
  localparam int unsigned POOL_W         = IMG_WIDHT_DEF / 2;
  localparam int unsigned POOL_H         = IMG_HEIGHT_DEF / 2;
  localparam int unsigned BUS_W          = DATA_WIDHT_DEF * CHANNELS;

  // Extract channel c from a packed pixel bus.
  function automatic logic [DATA_WIDHT_DEF-1:0] lane(input logic [BUS_W-1:0] bus,
                                                     input int unsigned c);
    return bus[c*DATA_WIDHT_DEF +: DATA_WIDHT_DEF];
  endfunction

endpackage

// File: rtl/max_compare_64lane.sv
// Per-lane signed maximum of two packed multi-channel buses (combinational).
module max_compare_64lane #(
  parameter int unsigned DATA_WIDHT = 32,
  parameter int unsigned LANES      = 64
) (
  input  logic [DATA_WIDHT*LANES-1:0] a,
  input  logic [DATA_WIDHT*LANES-1:0] b,
  output logic [DATA_WIDHT*LANES-1:0] max_c
);

  for (genvar c = 0; c < LANES; c++) begin : g_lane
    logic signed [DATA_WIDHT-1:0] a_s;
    logic signed [DATA_WIDHT-1:0] b_s;
    assign a_s = a[c*DATA_WIDHT +: DATA_WIDHT];
    assign b_s = b[c*DATA_WIDHT +: DATA_WIDHT];
    assign max_c[c*DATA_WIDHT +: DATA_WIDHT] = (a_s >= b_s) ? a_s : b_s;
  end

endmodule

// File: rtl/maxpool_2x2_64channel_layer5.sv
// Streaming 2x2 stride-2 max pooling over 64 channels, one line buffer of
// horizontal maxima, no backpressure.
module maxpool_2x2_64channel_layer5
  import maxpool_2x2_64channel_layer5_pkg::*;
#(
  parameter int unsigned DATA_WIDHT = DATA_WIDHT_DEF,
  parameter int unsigned IMG_WIDHT  = IMG_WIDHT_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
  input  logic                           Valid_In,
  output logic [DATA_WIDHT*CHANNELS-1:0] Data_Out,
  output logic                           Valid_Out
);

  localparam int unsigned BW       = DATA_WIDHT * CHANNELS;
  localparam int unsigned COL_W    = $clog2(IMG_WIDHT);
  localparam int unsigned ROW_W    = $clog2(IMG_HEIGHT);
  localparam int unsigned LB_DEPTH = IMG_WIDHT / 2;
  localparam int unsigned LB_AW    = $clog2(LB_DEPTH);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [BW-1:0]    hold_q, hold_d;
  logic [BW-1:0]    data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;

  logic [BW-1:0]    line_buf_q [LB_DEPTH];
  logic [LB_AW-1:0] lb_idx;
  logic [BW-1:0]    lb_rd;
  logic             lb_wr_en;
  logic [BW-1:0]    hmax;
  logic [BW-1:0]    vmax;

  assign lb_idx = LB_AW'(col_q >> 1);
  assign lb_rd  = line_buf_q[lb_idx];

  max_compare_64lane #(.DATA_WIDHT(DATA_WIDHT), .LANES(CHANNELS)) u_hmax (
    .a     (hold_q),
    .b     (Data_In),
    .max_c (hmax)
  );

  max_compare_64lane #(.DATA_WIDHT(DATA_WIDHT), .LANES(CHANNELS)) u_vmax (
    .a     (lb_rd),
    .b     (hmax),
    .max_c (vmax)
  );

  // Raster position tracking and per-beat action selection.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    lb_wr_en    = 1'b0;
    if (Valid_In) begin
      if (col_q == COL_W'(IMG_WIDHT - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (!col_q[0]) begin
        hold_d = Data_In;
      end else if (!row_q[0]) begin
        lb_wr_en = 1'b1;
      end else begin
        data_out_d  = vmax;
        valid_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Always written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (lb_wr_en) begin
      line_buf_q[lb_idx] <= hmax;
    end
  end

  assign Data_Out  = data_out_q;
  assign Valid_Out = valid_out_q;

endmodule

// File: tb/tb_maxpool_2x2_64channel_layer5.sv
// Directed bench for the layer-5 2x2 max-pool: window vectors plus frame-level sequences.
module tb_maxpool_2x2_64channel_layer5;
  import maxpool_2x2_64channel_layer5_pkg::*;

  localparam int W  = 44;
  localparam int H  = 44;
  localparam int PW = 22;
  localparam int PH = 22;
  localparam int NOUT = PW * PH;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [BUS_W-1:0]  Data_In = '0;
  logic              Valid_In = 1'b0;
  logic [BUS_W-1:0]  Data_Out;
  logic              Valid_Out;

  maxpool_2x2_64channel_layer5 dut (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .Data_Out  (Data_Out),
    .Valid_Out (Valid_Out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Monitor state (written only by the monitor processes).
  logic [BUS_W-1:0] out_q[$];
  int               stamp_q[$];
  int               vin_count = 0;
  int               viol_cnt  = 0;
  logic             vin_prev  = 1'b0;
  logic             vout_prev = 1'b0;

  always @(posedge clk) begin
    vin_prev <= Valid_In && rst;
    if (Valid_In && rst) vin_count <= vin_count + 1;
  end

  always @(negedge clk) begin
    if (Valid_Out) begin
      if (!vin_prev || vout_prev) viol_cnt = viol_cnt + 1;
      out_q.push_back(Data_Out);
      stamp_q.push_back(vin_count);
    end
    vout_prev = Valid_Out;
  end

  // ---------------- model ----------------
  function automatic logic [31:0] pix_val(input int kind, input int r, input int x, input int c);
    if (kind == 0) return 32'(r*W + x + c);
    return 32'(100000 - (r*W + x)*3 + c*5);
  endfunction

  function automatic logic [BUS_W-1:0] pix_bus(input int kind, input int r, input int x);
    logic [BUS_W-1:0] b;
    for (int c = 0; c < 64; c++) b[c*32 +: 32] = pix_val(kind, r, x, c);
    return b;
  endfunction

  function automatic logic [BUS_W-1:0] exp_bus(input int kind, input int i, input int j);
    logic [BUS_W-1:0] b;
    logic signed [31:0] m, t;
    for (int c = 0; c < 64; c++) begin
      m = $signed(pix_val(kind, 2*i, 2*j, c));
      for (int k = 1; k < 4; k++) begin
        t = $signed(pix_val(kind, 2*i + k/2, 2*j + k%2, c));
        if (t > m) m = t;
      end
      b[c*32 +: 32] = m;
    end
    return b;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_bus(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      failures++;
      bad = 0;
      for (int c = 63; c >= 0; c--) if (lane(act, c) !== lane(exp, c)) bad = c;
      $display("FAIL %s lane=%0d actual=%h required=%h", name, bad, lane(act, bad), lane(exp, bad));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic beat(input logic [BUS_W-1:0] d, input logic v);
    @(negedge clk);
    Data_In  = d;
    Valid_In = v;
  endtask

  task automatic idle(input int n);
    repeat (n) beat('0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; Valid_In = 1'b0; Data_In = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(input int kind, input logic gap);
    int cyc = 0;
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++) begin
        if (gap && (cyc % 3 == 2)) begin
          beat('0, 1'b0);
          cyc++;
        end
        beat(pix_bus(kind, r, x), 1'b1);
        cyc++;
      end
  endtask

  task automatic check_frame(input string name, input int kind, input int base);
    logic [BUS_W-1:0] act;
    for (int i = 0; i < PH; i++)
      for (int j = 0; j < PW; j++) begin
        if (base + i*PW + j < out_q.size()) act = out_q[base + i*PW + j];
        else act = 'x;
        check_bus($sformatf("%s_out_%0d_%0d", name, i, j), act, exp_bus(kind, i, j));
      end
  endtask

  // ---------------- window vectors ----------------
  typedef struct {
    string       name;
    logic [31:0] v [4];
    logic        perlane;
    logic [31:0] hi;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic pl, input logic [31:0] hi, input logic [31:0] e);
    vec_t t;
    t.name = n; t.v[0] = a; t.v[1] = b; t.v[2] = c; t.v[3] = d;
    t.perlane = pl; t.hi = hi; t.exp = e;
    return t;
  endfunction

  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] MAXV = 32'h7fff_ffff;

  initial begin
    vec_t vecs[7];
    logic [BUS_W-1:0] p[4];
    logic [BUS_W-1:0] e;
    int base, vbase, vin_base;

    vecs[0] = mk("neg_mix",   -32'sd5, -32'sd1, -32'sd7, MINV, 1'b0, 32'd0, -32'sd1);
    vecs[1] = mk("all_min",   MINV, MINV, MINV, MINV, 1'b0, 32'd0, MINV);
    vecs[2] = mk("pos_mix",   32'd3, 32'd9, 32'd2, 32'd4, 1'b0, 32'd0, 32'd9);
    vecs[3] = mk("max_vs_neg", MAXV, 32'd0, -32'sd1, 32'd5, 1'b0, 32'd0, MAXV);
    vecs[4] = mk("all_equal", -32'sd1, -32'sd1, -32'sd1, -32'sd1, 1'b0, 32'd0, -32'sd1);
    vecs[5] = mk("per_lane",  -32'sd100, -32'sd100, -32'sd100, -32'sd100, 1'b1, 32'd50, 32'd0);
    vecs[6] = mk("min_plus1", MINV, MINV, 32'h8000_0001, MINV, 1'b0, 32'd0, 32'h8000_0001);

    // Reset state
    repeat (2) @(negedge clk);
    check_int("reset_valid_out", int'(Valid_Out), 0);
    check_bus("reset_data_out", Data_Out, '0);
    rst = 1'b1;

    // Single-window vectors: row 0 then first two beats of row 1.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 64; c++)
          p[k][c*32 +: 32] = (vecs[v].perlane && (k == c % 4)) ? vecs[v].hi + 32'(c) : vecs[v].v[k];
      for (int c = 0; c < 64; c++)
        e[c*32 +: 32] = vecs[v].perlane ? vecs[v].hi + 32'(c) : vecs[v].exp;
      beat(p[0], 1'b1);
      beat(p[1], 1'b1);
      for (int x = 2; x < W; x++) beat('0, 1'b1);
      beat(p[2], 1'b1);
      beat(p[3], 1'b1);
      beat('0, 1'b0);
      check_int({vecs[v].name, "_valid"}, int'(Valid_Out), 1);
      check_bus({vecs[v].name, "_data"}, Data_Out, e);
    end

    // Continuous ramp frame
    do_reset();
    base = out_q.size(); vbase = viol_cnt; vin_base = vin_count;
    send_frame(0, 1'b0);
    idle(4);
    check_int("ramp_count", out_q.size() - base, NOUT);
    check_int("ramp_first_latency", (stamp_q.size() > base) ? stamp_q[base] - vin_base : -1, 46);
    check_int("ramp_strobe_rules", viol_cnt - vbase, 0);
    check_frame("ramp", 0, base);

    // Gappy ramp frame
    do_reset();
    base = out_q.size(); vbase = viol_cnt;
    send_frame(0, 1'b1);
    idle(4);
    check_int("gappy_count", out_q.size() - base, NOUT);
    check_int("gappy_strobe_rules", viol_cnt - vbase, 0);
    check_frame("gappy", 0, base);

    // Back-to-back frames
    do_reset();
    base = out_q.size(); vbase = viol_cnt;
    send_frame(0, 1'b0);
    send_frame(1, 1'b0);
    idle(4);
    check_int("b2b_count", out_q.size() - base, 2*NOUT);
    check_int("b2b_strobe_rules", viol_cnt - vbase, 0);
    check_frame("b2b_f0", 0, base);
    check_frame("b2b_f1", 1, base + NOUT);

    // Reset mid-frame at row 10, col 7
    do_reset();
    for (int r = 0; r <= 10; r++)
      for (int x = 0; x < W; x++)
        if (r < 10 || x < 7) beat(pix_bus(1, r, x), 1'b1);
    @(negedge clk);
    rst = 1'b0; Valid_In = 1'b0; Data_In = '0;
    @(negedge clk);
    check_int("midrst_valid_out", int'(Valid_Out), 0);
    check_bus("midrst_data_out", Data_Out, '0);
    @(negedge clk);
    rst = 1'b1;
    base = out_q.size(); vbase = viol_cnt;
    send_frame(0, 1'b0);
    idle(4);
    check_int("midrst_count", out_q.size() - base, NOUT);
    check_int("midrst_strobe_rules", viol_cnt - vbase, 0);
    check_frame("midrst", 0, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
